// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider for the HI/LO write port: one quotient bit per cycle.
// Define DIV_SIGNED_EN to compile in signed (DIV) support; otherwise every divide is unsigned.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        annul_i,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        hilo_we_o,
  output logic        ready_o,
  output logic        stall_o
);

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

  state_t      state, state_nx;
  logic [5:0]  cnt;
  logic [31:0] dvd_raw;   // dividend as presented, returned as HI on divide-by-zero
  logic [31:0] quo, rem, dvs;
  logic [31:0] res_lo, res_hi;
  logic        neg_q, neg_r;
  logic        we_done;

  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b;

`ifdef DIV_SIGNED_EN
  assign neg_a = signed_i & opdata1_i[31];
  assign neg_b = signed_i & opdata2_i[31];
`else
  logic unused_signed;
  assign unused_signed = signed_i;
  assign neg_a = 1'b0;
  assign neg_b = 1'b0;
`endif

  assign mag_a = neg_a ? -opdata1_i : opdata1_i;
  assign mag_b = neg_b ? -opdata2_i : opdata2_i;

  // Restoring step: shift the next dividend bit into the partial remainder, subtract if it fits.
  logic [32:0] trial;
  logic        ge;
  logic [31:0] rem_nx, quo_nx, lo_fin, hi_fin;

  always_comb begin
    trial  = {rem, quo[31]};
    ge     = (trial >= {1'b0, dvs});
    rem_nx = ge ? 32'(trial - {1'b0, dvs}) : trial[31:0];
    quo_nx = {quo[30:0], ge};
    lo_fin = neg_q ? -quo_nx : quo_nx;
    hi_fin = neg_r ? -rem_nx : rem_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    stall_o   = 1'b0;
    ready_o   = 1'b0;
    hilo_we_o = 1'b0;
    hi_o      = 32'd0;
    lo_o      = 32'd0;
    case (state)
      S_IDLE: begin
        if (start_i && !annul_i && !rst) begin
          stall_o  = 1'b1;
          state_nx = (opdata2_i == 32'd0) ? S_BYZERO : S_ON;
        end
      end
      S_BYZERO: begin
        stall_o  = 1'b1;
        state_nx = annul_i ? S_IDLE : S_END;
      end
      S_ON: begin
        stall_o = 1'b1;
        if (annul_i)             state_nx = S_IDLE;
        else if (cnt == 6'd31)   state_nx = S_END;
      end
      S_END: begin
        ready_o   = 1'b1;
        hi_o      = res_hi;
        lo_o      = res_lo;
        hilo_we_o = !we_done;
        if (!start_i) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 6'd0;
      dvd_raw <= 32'd0;
      quo     <= 32'd0;
      rem     <= 32'd0;
      dvs     <= 32'd0;
      res_lo  <= 32'd0;
      res_hi  <= 32'd0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      we_done <= 1'b0;
    end else begin
      // END is always entered from a non-END state, so this is clear on the first END cycle.
      we_done <= (state == S_END);
      case (state)
        S_IDLE: begin
          if (start_i && !annul_i) begin
            dvd_raw <= opdata1_i;
            quo     <= mag_a;
            dvs     <= mag_b;
            rem     <= 32'd0;
            cnt     <= 6'd0;
            neg_q   <= neg_a ^ neg_b;
            neg_r   <= neg_a;
          end
        end
        S_BYZERO: begin
          if (!annul_i) begin
            res_lo <= 32'hFFFF_FFFF;
            res_hi <= dvd_raw;
          end
        end
        S_ON: begin
          if (annul_i) begin
            cnt <= 6'd0;
          end else begin
            quo <= quo_nx;
            rem <= rem_nx;
            if (cnt == 6'd31) begin
              cnt    <= 6'd0;
              res_lo <= lo_fin;
              res_hi <= hi_fin;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
